// File: rtl/axi_rd_master.sv
// axi_rd_master
//   AXI3 read master. Read requests (address, length, beat size) are queued in
//   a small request FIFO and issued on the AR channel with incrementing IDs,
//   never exceeding MAX_OUT bursts in flight. R beats are passed straight
//   through to a streaming consumer. Each beat is checked against the expected
//   ID and the expected burst length.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   req_*                request input (valid/ready)
//   ar*                  AXI3 read address channel (master side)
//   r*                   AXI3 read data channel (master side)
//   dout_*               streaming output of R beats, plus a per-beat error flag
//   err_sticky           set by any accepted beat in error; cleared only by reset
//   outstanding          bursts issued on AR but not yet retired
//   idle                 request FIFO empty, no AR pending, nothing outstanding
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, the payload holds stable
// until that transfer.

module axi_rd_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int REQ_DEPTH = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LEN_W-1:0]             req_len,
  input  logic [2:0]                   req_size,
  output logic [ID_W-1:0]              arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [LEN_W-1:0]             arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_W-1:0]              rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [DATA_W-1:0]            dout_data,
  output logic                         dout_last,
  output logic                         dout_err,
  output logic                         err_sticky,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         idle
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int LP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(REQ_DEPTH);
  localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUT);
  localparam logic [LP_W-1:0]  LP_LAST = LP_W'(MAX_OUT - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  // Request FIFO storage
  logic [ADDR_W-1:0] addr_mem [REQ_DEPTH];
  logic [LEN_W-1:0]  len_mem  [REQ_DEPTH];
  logic [2:0]        size_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Expected-length FIFO, one entry per outstanding burst
  logic [LEN_W-1:0]  lfifo_mem [MAX_OUT];
  logic [LP_W-1:0]   lwr_ptr_q, lwr_ptr_d, lrd_ptr_q, lrd_ptr_d;

  // AR issue FSM and registered AR fields
  state_e            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [ID_W-1:0]   issue_cnt_q, issue_cnt_d;

  // R-side tracking
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [ID_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_sticky_q, err_sticky_d;

  logic              push, pop, ar_hs, r_hs, active, len_match, retire, beat_err;
  logic [LEN_W-1:0]  exp_len;
  logic              unused_rresp0;

  assign unused_rresp0 = rresp[0];

  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && (outstanding_q < MAX_C);
  assign ar_hs     = arvalid_q && arready;
  assign r_hs      = rvalid && dout_ready;
  assign active    = (outstanding_q != '0);
  assign exp_len   = lfifo_mem[lrd_ptr_q];
  assign len_match = (beat_cnt_q == exp_len);
  // A burst retires on its rlast, or on its last expected beat if rlast is missing.
  assign retire    = r_hs && active && (rlast || len_match);
  // With nothing outstanding there is no burst a beat can belong to.
  assign beat_err  = active ? (rresp[1] || (rid != retire_cnt_q) || (rlast != len_match))
                            : 1'b1;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    lwr_ptr_d     = lwr_ptr_q;
    lrd_ptr_d     = lrd_ptr_q;
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    arid_d        = arid_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arsize_d      = arsize_q;
    issue_cnt_d   = issue_cnt_q;
    outstanding_d = outstanding_q;
    retire_cnt_d  = retire_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    err_sticky_d  = err_sticky_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_ISSUE;
          arvalid_d = 1'b1;
          arid_d    = issue_cnt_q;
          araddr_d  = addr_mem[rd_ptr_q];
          arlen_d   = len_mem[rd_ptr_q];
          arsize_d  = size_mem[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        if (arready) begin
          state_d     = S_IDLE;
          arvalid_d   = 1'b0;
          issue_cnt_d = issue_cnt_q + ID_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case ({ar_hs, retire})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // MAX_OUT need not be a power of two, so wrap explicitly.
    if (ar_hs)  lwr_ptr_d = (lwr_ptr_q == LP_LAST) ? '0 : lwr_ptr_q + LP_W'(1);
    if (retire) lrd_ptr_d = (lrd_ptr_q == LP_LAST) ? '0 : lrd_ptr_q + LP_W'(1);

    if (r_hs && active) begin
      beat_cnt_d = retire ? '0 : beat_cnt_q + LEN_W'(1);
    end
    if (retire) retire_cnt_d = retire_cnt_q + ID_W'(1);

    if (r_hs && beat_err) err_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      lwr_ptr_q     <= '0;
      lrd_ptr_q     <= '0;
      state_q       <= S_IDLE;
      arvalid_q     <= 1'b0;
      arid_q        <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arsize_q      <= '0;
      issue_cnt_q   <= '0;
      outstanding_q <= '0;
      retire_cnt_q  <= '0;
      beat_cnt_q    <= '0;
      err_sticky_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      lwr_ptr_q     <= lwr_ptr_d;
      lrd_ptr_q     <= lrd_ptr_d;
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      arid_q        <= arid_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arsize_q      <= arsize_d;
      issue_cnt_q   <= issue_cnt_d;
      outstanding_q <= outstanding_d;
      retire_cnt_q  <= retire_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= req_addr;
      len_mem[wr_ptr_q]  <= req_len;
      size_mem[wr_ptr_q] <= req_size;
    end
    if (ar_hs) lfifo_mem[lwr_ptr_q] <= arlen_q;
  end

  assign req_ready   = (count_q < DEPTH_C);
  assign arvalid     = arvalid_q;
  assign arid        = arid_q;
  assign araddr      = araddr_q;
  assign arlen       = arlen_q;
  assign arsize      = arsize_q;
  assign arburst     = 2'b01;
  assign rready      = dout_ready;
  assign dout_valid  = rvalid;
  assign dout_data   = rdata;
  assign dout_last   = rlast;
  assign dout_err    = beat_err;
  assign err_sticky  = err_sticky_q;
  assign outstanding = outstanding_q;
  assign idle        = (count_q == '0) && !arvalid_q && (outstanding_q == '0);

endmodule

// File: tb/tb_axi_rd_master.sv
module tb_axi_rd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int AR_W   = ID_W + ADDR_W + LEN_W + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [2:0]        req_size = '0;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [ID_W-1:0]   rid = '0;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic [DATA_W-1:0] dout_data;
  logic              dout_last;
  logic              dout_err;
  logic              err_sticky;
  logic [2:0]        outstanding;
  logic              idle;

  axi_rd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
    .REQ_DEPTH(4), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .dout_err(dout_err), .err_sticky(err_sticky),
    .outstanding(outstanding), .idle(idle)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int ar_hs_cnt = 0;
  logic [ID_W-1:0] next_id = '0;
  logic [AR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AR monitor: sampled on the falling edge, the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && arvalid && arready) begin
      ar_hs_cnt++;
      check("ar_burst", 64'(arburst), 64'(2'b01));
      if (exp_q.size() == 0) begin
        check("ar_unexpected", 64'(1), 64'(0));
      end else begin
        check("ar_fields", 64'({arid, araddr, arlen, arsize}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    exp_q.delete();
    next_id = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic push_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          input logic [2:0] s);
    bit done = 0;
    req_valid = 1'b1; req_addr = a; req_len = l; req_size = s;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({next_id, a, l, s});
        next_id = next_id + 1'b1;
        done = 1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) check("req_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic beat(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                      input logic [1:0] resp, input logic last, input logic exp_err);
    rvalid = 1'b1; rid = id; rdata = d; rresp = resp; rlast = last;
    @(negedge clk);
    check("dout_valid", 64'(dout_valid), 64'(1));
    check("dout_data", 64'(dout_data), 64'(d));
    check("dout_last", 64'(dout_last), 64'(last));
    check("dout_err", 64'(dout_err), 64'(exp_err));
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic wait_outstanding(input string tag, input int val);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (outstanding == 3'(val)) hit = 1;
    end
    check(tag, 64'(outstanding), 64'(val));
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [LEN_W-1:0] lens  [6] = '{4'd1, 4'd1, 4'd1, 4'd3, 4'd1, 4'd2};
  logic [2:0]       sizes [6] = '{3'd2, 3'd2, 3'd1, 3'd2, 3'd0, 3'd2};

  initial begin
    int n_acc;
    int base;
    bit adv;

    // Reset values, checked while reset is held
    #12;
    rvalid = 1'b1; rdata = 32'hCAFE_0001; rlast = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_arvalid", 64'(arvalid), 64'(0));
    check("rst_ar_fields", 64'({arid, araddr, arlen, arsize}), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_err_sticky", 64'(err_sticky), 64'(0));
    check("rst_dout_pass", 64'({dout_valid, dout_last, dout_data}), 64'({2'b11, 32'hCAFE_0001}));
    rvalid = 1'b0; rlast = 1'b0;
    apply_reset();

    // Single burst with one cycle of request-to-AR latency
    arready = 1'b1;
    push_req(32'h1000, 4'd3, 3'd2);
    @(negedge clk);
    check("ar_latency_early", 64'(arvalid), 64'(0));
    tick();
    @(negedge clk);
    check("ar_latency_on", 64'(arvalid), 64'(1));
    tick();
    @(negedge clk);
    check("single_outstanding_1", 64'(outstanding), 64'(1));
    tick();
    for (int i = 0; i < 4; i++) beat(4'd0, 32'hA000_0000 + 32'(i), 2'b00, (i == 3), 1'b0);
    @(negedge clk);
    check("single_outstanding_0", 64'(outstanding), 64'(0));
    check("single_idle", 64'(idle), 64'(1));
    check("single_err_sticky", 64'(err_sticky), 64'(0));
    tick();

    // Stalled AR: FIFO fills, AR fields hold
    apply_reset();
    arready = 1'b0;
    n_acc = 0;
    req_valid = 1'b1; req_addr = 32'h2000; req_len = lens[0]; req_size = sizes[0];
    for (int c = 0; c < 12; c++) begin
      adv = 0;
      @(negedge clk);
      if (req_ready && n_acc < 6) begin
        exp_q.push_back({next_id, req_addr, req_len, req_size});
        next_id = next_id + 1'b1;
        n_acc++;
        adv = 1;
      end
      tick();
      if (adv && n_acc < 6) begin
        req_addr = 32'h2000 + 32'(n_acc) * 32'h40;
        req_len  = lens[n_acc];
        req_size = sizes[n_acc];
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("stall_accepted", 64'(n_acc), 64'(5));
    check("stall_req_ready", 64'(req_ready), 64'(0));
    check("stall_arvalid", 64'(arvalid), 64'(1));
    check("stall_ar_fields", 64'({arid, araddr, arlen, arsize}),
          64'({4'd0, 32'h2000, 4'd1, 3'd2}));
    tick();

    // Release AR: only MAX_OUT bursts may be in flight
    base = ar_hs_cnt;
    arready = 1'b1;
    push_req(32'h2000 + 32'd5 * 32'h40, lens[5], sizes[5]);
    repeat (15) tick();
    @(negedge clk);
    check("maxout_ar_count", 64'(ar_hs_cnt - base), 64'(4));
    check("maxout_outstanding", 64'(outstanding), 64'(4));
    check("maxout_arvalid", 64'(arvalid), 64'(0));
    tick();

    // Burst 0 completes -> fifth AR (arid 4) goes out
    beat(4'd0, 32'hB000_0000, 2'b00, 1'b0, 1'b0);
    beat(4'd0, 32'hB000_0001, 2'b00, 1'b1, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("fifth_ar_count", 64'(ar_hs_cnt - base), 64'(5));
    check("fifth_outstanding", 64'(outstanding), 64'(4));
    tick();

    // Burst 1: SLVERR beat
    beat(4'd1, 32'hB100_0000, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    check("sticky_set", 64'(err_sticky), 64'(1));
    tick();
    beat(4'd1, 32'hB100_0001, 2'b00, 1'b1, 1'b0);
    // Burst 2: wrong rid on the first beat
    beat(4'd7, 32'hB200_0000, 2'b00, 1'b0, 1'b1);
    beat(4'd2, 32'hB200_0001, 2'b00, 1'b1, 1'b0);
    // Burst 3: len 3, early rlast on beat 1
    beat(4'd3, 32'hB300_0000, 2'b00, 1'b0, 1'b0);
    beat(4'd3, 32'hB300_0001, 2'b00, 1'b1, 1'b1);
    // Burst 4: clean, proves exp_id moved on past the early-terminated burst
    beat(4'd4, 32'hB400_0000, 2'b00, 1'b0, 1'b0);
    beat(4'd4, 32'hB400_0001, 2'b00, 1'b1, 1'b0);
    // Burst 5: len 2, rlast never arrives; retires on beat 2 with error
    beat(4'd5, 32'hB500_0000, 2'b00, 1'b0, 1'b0);
    beat(4'd5, 32'hB500_0001, 2'b00, 1'b0, 1'b0);
    beat(4'd5, 32'hB500_0002, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check("drain_outstanding", 64'(outstanding), 64'(0));
    check("drain_idle", 64'(idle), 64'(1));
    check("drain_ar_queue", 64'(exp_q.size()), 64'(0));
    check("sticky_held", 64'(err_sticky), 64'(1));
    tick();

    // Stray beat with nothing outstanding
    beat(4'd6, 32'hC000_0000, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    check("stray_outstanding", 64'(outstanding), 64'(0));
    tick();

    // rready follows dout_ready
    dout_ready = 1'b0; rvalid = 1'b1;
    @(negedge clk);
    check("rready_low", 64'(rready), 64'(0));
    tick();
    dout_ready = 1'b1; rvalid = 1'b0;

    // Asynchronous reset with two bursts outstanding
    push_req(32'h4000, 4'd3, 3'd2);
    push_req(32'h4100, 4'd3, 3'd2);
    wait_outstanding("pre_reset_outstanding", 2);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rst_arvalid", 64'(arvalid), 64'(0));
    check("mid_rst_outstanding", 64'(outstanding), 64'(0));
    check("mid_rst_idle", 64'(idle), 64'(1));
    check("mid_rst_err_sticky", 64'(err_sticky), 64'(0));
    check("mid_rst_ar_fields", 64'({arid, araddr, arlen, arsize}), 64'(0));
    exp_q.delete();
    next_id = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // After reset, IDs restart from 0
    base = ar_hs_cnt;
    push_req(32'h5000, 4'd0, 3'd2);
    wait_outstanding("post_rst_outstanding", 1);
    check("post_rst_ar_count", 64'(ar_hs_cnt - base), 64'(1));
    beat(4'd0, 32'hD000_0000, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_idle", 64'(idle), 64'(1));
    check("post_rst_ar_queue", 64'(exp_q.size()), 64'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
